// File: rtl/jpeg_rle_reader.sv
// Walks one quantized 8x8 block out of the DCT output RAM in zig-zag order and
// emits JPEG run/level symbols (DC, AC, ZRL, EOB) on a valid/ready stream.
module jpeg_rle_reader #(
   parameter int MEM_AW   = 9,
   parameter int BLK_BASE = 0,
   parameter int COEF_W   = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic [MEM_AW-1:0]        mem_adr_o,
   input  logic [31:0]              mem_dat_i,
   output logic                     rl_valid_o,
   input  logic                     rl_ready_i,
   output logic [3:0]               rl_run_o,
   output logic signed [COEF_W-1:0] rl_level_o,
   output logic                     rl_dc_o,
   output logic                     rl_eob_o
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SCAN, S_EMIT, S_DONE} state_t;

   // Zig-zag index k -> raster index 8*row+col
   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63};

   function automatic logic [MEM_AW-1:0] f_adr(input logic [5:0] k);
      f_adr = MEM_AW'(BLK_BASE) + MEM_AW'(ZZ[k][5:1]);
   endfunction

   state_t                     r_state;
   logic [5:0]                 r_k;
   logic [5:0]                 r_zero_run;
   logic signed [COEF_W-1:0]   r_coef_q;
   logic                       r_zrl_pend;
   logic                       r_busy;
   logic                       r_done;
   logic [MEM_AW-1:0]          r_mem_adr;
   logic                       r_valid;
   logic [3:0]                 r_run;
   logic signed [COEF_W-1:0]   r_level;
   logic                       r_dc;
   logic                       r_eob;

   logic [15:0]                w_half;
   logic signed [COEF_W-1:0]   w_coef;
   logic [5:0]                 w_k_next;
   logic [5:0]                 w_run_left;

   // Address is registered on entry to FETCH, so RAM data lands in SCAN
   assign w_half     = ZZ[r_k][0] ? mem_dat_i[31:16] : mem_dat_i[15:0];
   assign w_coef     = COEF_W'($signed(w_half));
   assign w_k_next   = r_k + 6'd1;
   assign w_run_left = r_zero_run - 6'd16;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_k        <= '0;
         r_zero_run <= '0;
         r_coef_q   <= '0;
         r_zrl_pend <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mem_adr  <= MEM_AW'(BLK_BASE);
         r_valid    <= 1'b0;
         r_run      <= '0;
         r_level    <= '0;
         r_dc       <= 1'b0;
         r_eob      <= 1'b0;
      end else begin
         // NOTE: default first so done_o is a single-cycle pulse without extra decode
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_busy     <= 1'b1;
                  r_k        <= '0;
                  r_zero_run <= '0;
                  r_zrl_pend <= 1'b0;
                  r_mem_adr  <= f_adr(6'd0);
                  r_state    <= S_FETCH;
               end
            end
            S_FETCH: r_state <= S_SCAN;
            S_SCAN: begin
               r_coef_q <= w_coef;
               r_valid  <= 1'b1;
               r_run    <= '0;
               r_level  <= '0;
               r_dc     <= 1'b0;
               r_eob    <= 1'b0;
               r_state  <= S_EMIT;
               if (r_k == 6'd0) begin
                  r_dc    <= 1'b1;
                  r_level <= w_coef;
               end else if (w_coef == '0) begin
                  if (r_k == 6'd63) begin
                     r_eob <= 1'b1;
                  end else begin
                     r_valid    <= 1'b0;
                     r_zero_run <= r_zero_run + 6'd1;
                     r_k        <= w_k_next;
                     r_mem_adr  <= f_adr(w_k_next);
                     r_state    <= S_FETCH;
                  end
               end else if (r_zero_run >= 6'd16) begin
                  r_run      <= 4'd15;
                  r_zrl_pend <= 1'b1;
               end else begin
                  r_run   <= r_zero_run[3:0];
                  r_level <= w_coef;
               end
            end
            S_EMIT: begin
               if (rl_ready_i) begin
                  if (r_zrl_pend) begin
                     // Outputs already hold a ZRL; only the tail symbol needs loading
                     r_zero_run <= w_run_left;
                     if (w_run_left < 6'd16) begin
                        r_run      <= w_run_left[3:0];
                        r_level    <= r_coef_q;
                        r_zrl_pend <= 1'b0;
                     end
                  end else if (r_eob || r_k == 6'd63) begin
                     r_valid    <= 1'b0;
                     r_zero_run <= '0;
                     r_busy     <= 1'b0;
                     r_done     <= 1'b1;
                     r_state    <= S_DONE;
                  end else begin
                     r_valid    <= 1'b0;
                     r_zero_run <= '0;
                     r_k        <= w_k_next;
                     r_mem_adr  <= f_adr(w_k_next);
                     r_state    <= S_FETCH;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign mem_adr_o  = r_mem_adr;
   assign rl_valid_o = r_valid;
   assign rl_run_o   = r_run;
   assign rl_level_o = r_level;
   assign rl_dc_o    = r_dc;
   assign rl_eob_o   = r_eob;

endmodule

// File: tb/tb_jpeg_rle_reader.sv
// Directed bench for jpeg_rle_reader: RAM model, symbol capture on handshake,
// hand-computed symbol sequences, stall stability, async reset and start masking.
module tb_jpeg_rle_reader;

   typedef struct packed {
      logic [3:0]         run;
      logic signed [15:0] level;
      logic               dc;
      logic               eob;
   } sym_t;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               busy;
   logic               done;
   logic [8:0]         mem_adr;
   logic [31:0]        mem_dat;
   logic               valid;
   logic               ready;
   logic [3:0]         run;
   logic signed [15:0] level;
   logic               dc;
   logic               eob;

   logic [31:0] mem [512];
   sym_t        got_q [$];
   sym_t        exp_q [$];
   int          done_cnt = 0;
   int          n_tests  = 0;
   int          n_fail   = 0;
   int          cycles;
   int          guard;
   logic        prev_stall = 1'b0;
   sym_t        held;

   jpeg_rle_reader #(.MEM_AW(9), .BLK_BASE(0), .COEF_W(16)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .busy_o     (busy),
      .done_o     (done),
      .mem_adr_o  (mem_adr),
      .mem_dat_i  (mem_dat),
      .rl_valid_o (valid),
      .rl_ready_i (ready),
      .rl_run_o   (run),
      .rl_level_o (level),
      .rl_dc_o    (dc),
      .rl_eob_o   (eob)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mem_dat <= mem[mem_adr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Capture accepted symbols, count done pulses, and check hold-while-stalled
   always @(posedge clk) begin
      if (!rst) begin
         if (prev_stall) begin
            check("stall_valid_held", 32'(valid), 32'd1);
            check("stall_sym_held", 32'({run, level, dc, eob}), 32'(held));
         end
         if (valid && ready) got_q.push_back({run, level, dc, eob});
         if (done) done_cnt++;
         prev_stall = valid && !ready;
         held       = {run, level, dc, eob};
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic sym_t mk(input int r, input int lv, input bit d, input bit e);
      sym_t s;
      s.run   = 4'(r);
      s.level = 16'(lv);
      s.dc    = d;
      s.eob   = e;
      return s;
   endfunction

   task automatic clear_mem();
      foreach (mem[i]) mem[i] = '0;
   endtask

   task automatic set_coef(input int r, input int val);
      if (r % 2 == 1) mem[r / 2][31:16] = 16'(val);
      else            mem[r / 2][15:0]  = 16'(val);
   endtask

   task automatic load_case2();
      clear_mem();
      set_coef(0, 5);
      set_coef(1, -3);
      set_coef(63, 7);
      exp_q = {};
      exp_q.push_back(mk(0, 5, 1, 0));
      exp_q.push_back(mk(0, -3, 0, 0));
      exp_q.push_back(mk(15, 0, 0, 0));
      exp_q.push_back(mk(15, 0, 0, 0));
      exp_q.push_back(mk(15, 0, 0, 0));
      exp_q.push_back(mk(13, 7, 0, 0));
   endtask

   task automatic run_block(input string tag, input bit rnd, input bit poke, output int cyc);
      got_q.delete();
      done_cnt = 0;
      @(negedge clk);
      start = 1'b1;
      cyc   = 0;
      while (cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = poke && (cyc % 17 == 0) && (done_cnt == 0);
         if (rnd) ready = 1'($urandom_range(0, 1));
         if (done_cnt != 0) break;
      end
      start = 1'b0;
      ready = 1'b1;
      check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
   endtask

   task automatic compare_seq(input string tag);
      int n;
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_sym%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      ready = 1'b1;
      clear_mem();
      #12;
      check("rst_busy",  32'(busy),    32'd0);
      check("rst_done",  32'(done),    32'd0);
      check("rst_valid", 32'(valid),   32'd0);
      check("rst_run",   32'(run),     32'd0);
      check("rst_level", 32'(level),   32'd0);
      check("rst_dc",    32'(dc),      32'd0);
      check("rst_eob",   32'(eob),     32'd0);
      check("rst_adr",   32'(mem_adr), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // DC only, then EOB covering 63 trailing zeros
      clear_mem();
      set_coef(0, 16'h0010);
      exp_q = {};
      exp_q.push_back(mk(0, 16, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 1));
      run_block("dc_only", 1'b0, 1'b0, cycles);
      compare_seq("dc_only");
      check("dc_only_min_cycles", 32'(cycles >= 128), 32'd1);
      check("dc_only_busy_after", 32'(busy), 32'd0);

      // All-zero block: DC of zero is still coded
      clear_mem();
      exp_q = {};
      exp_q.push_back(mk(0, 0, 1, 0));
      exp_q.push_back(mk(0, 0, 0, 1));
      run_block("zero_blk", 1'b0, 1'b0, cycles);
      compare_seq("zero_blk");

      // Long run into coefficient 63: three ZRLs, no EOB
      load_case2();
      run_block("zrl", 1'b0, 1'b0, cycles);
      compare_seq("zrl");

      // Half select and zig-zag order: r2 sits at k=5, r3 at k=6
      clear_mem();
      set_coef(0, 1);
      set_coef(2, 16'h000A);
      set_coef(3, -2);
      exp_q = {};
      exp_q.push_back(mk(0, 1, 1, 0));
      exp_q.push_back(mk(4, 10, 0, 0));
      exp_q.push_back(mk(0, -2, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 1));
      run_block("half_sel", 1'b0, 1'b0, cycles);
      compare_seq("half_sel");

      // Random back-pressure must not change the sequence
      load_case2();
      run_block("stall", 1'b1, 1'b0, cycles);
      compare_seq("stall");

      // Async reset while the second ZRL is on the bus
      load_case2();
      got_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (got_q.size() < 3 && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      ready = 1'b0;
      check("rst_mid_reached", 32'(got_q.size()), 32'd3);
      check("rst_mid_zrl2_valid", 32'(valid), 32'd1);
      check("rst_mid_zrl2_run", 32'(run), 32'd15);
      check("rst_mid_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_async_valid", 32'(valid), 32'd0);
      check("rst_async_busy", 32'(busy), 32'd0);
      check("rst_async_adr", 32'(mem_adr), 32'd0);
      @(negedge clk);
      rst   = 1'b0;
      ready = 1'b1;
      run_block("after_rst", 1'b0, 1'b0, cycles);
      compare_seq("after_rst");

      // Start pulses while busy are ignored: one done per accepted start
      clear_mem();
      set_coef(0, 1);
      set_coef(2, 16'h000A);
      set_coef(3, -2);
      exp_q = {};
      exp_q.push_back(mk(0, 1, 1, 0));
      exp_q.push_back(mk(4, 10, 0, 0));
      exp_q.push_back(mk(0, -2, 0, 0));
      exp_q.push_back(mk(0, 0, 0, 1));
      run_block("restart", 1'b0, 1'b1, cycles);
      repeat (20) @(negedge clk);
      compare_seq("restart");
      check("restart_done_cnt", 32'(done_cnt), 32'd1);
      check("restart_idle_busy", 32'(busy), 32'd0);
      check("restart_idle_valid", 32'(valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
